// File: rtl/radar_frame_scheduler.sv
// Chirp-synchronous ADC capture sequencer: aligns samples to the ramp sync, fills
// ping-pong frame banks and hands complete banks to the USB reader.
module radar_frame_scheduler #(
  parameter int SAMPLES_PER_CHIRP = 256,
  parameter int CHIRPS_PER_FRAME  = 256,
  parameter int SKIP_SAMPLES      = 16,
  parameter int SYNC_TIMEOUT      = 60000,
  parameter int ADDR_W            = 16
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              sawtooth_dsync,
  input  logic              enable,
  input  logic              adc_valid,
  input  logic [15:0]       adc_data,
  output logic              wr_en,
  output logic [15:0]       wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bank,
  output logic [1:0]        bank_ready,
  input  logic [1:0]        bank_done,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        drop_cnt,
  output logic              chirp_err,
  output logic              timeout_err
);

  localparam int SW = (SAMPLES_PER_CHIRP > 1) ? $clog2(SAMPLES_PER_CHIRP) : 1;
  localparam int CW = (CHIRPS_PER_FRAME > 1) ? $clog2(CHIRPS_PER_FRAME) : 1;
  localparam int KW = (SKIP_SAMPLES > 0) ? $clog2(SKIP_SAMPLES + 1) : 1;
  localparam int TW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLES_PER_CHIRP - 1);
  localparam logic [CW-1:0] CHIRP_LAST  = CW'(CHIRPS_PER_FRAME - 1);
  localparam logic [KW-1:0] SKIP_LAST   = KW'((SKIP_SAMPLES > 0) ? SKIP_SAMPLES - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST    = TW'(SYNC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_SKIP      = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DROP      = 3'd4
  } state_t;

  localparam state_t FIRST_ST = (SKIP_SAMPLES == 0) ? ST_CAPTURE : ST_SKIP;

  state_t            state_r, state_s, start_state_s;
  logic              sync_meta_r, sync_sync_r, sync_prev_r, sync_rise_s;
  logic [CW-1:0]     chirp_idx_r, chirp_idx_s;
  logic [SW-1:0]     sample_idx_r, sample_idx_s;
  logic [KW-1:0]     skip_cnt_r, skip_cnt_s;
  logic [TW-1:0]     tmo_cnt_r, tmo_cnt_s;
  logic              bank_sel_r, bank_sel_s;
  logic [1:0]        bank_ready_r, bank_ready_s, set_mask_s;
  logic [15:0]       frame_cnt_r, frame_cnt_s;
  logic [7:0]        drop_cnt_r, drop_cnt_s, drop_next_s;
  logic              wr_en_r, wr_en_s;
  logic [15:0]       wr_data_r, wr_data_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic              wr_bank_r;
  logic              chirp_err_r, chirp_err_s;
  logic              timeout_err_r, timeout_err_s;

  assign sync_rise_s = sync_sync_r & ~sync_prev_r;

  // Frame-start decision shared by WAIT_SYNC, DROP and chirp-abort restarts
  always_comb begin
    start_state_s = FIRST_ST;
    drop_next_s   = drop_cnt_r;
    if (bank_ready_r[bank_sel_r]) begin
      start_state_s = ST_DROP;
      if (drop_cnt_r != 8'hFF) begin
        drop_next_s = drop_cnt_r + 8'd1;
      end else begin
        drop_next_s = drop_cnt_r;
      end
    end else if (!enable) begin
      start_state_s = ST_IDLE;
    end else begin
      start_state_s = FIRST_ST;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s       = state_r;
    chirp_idx_s   = chirp_idx_r;
    sample_idx_s  = sample_idx_r;
    skip_cnt_s    = skip_cnt_r;
    tmo_cnt_s     = '0;
    bank_sel_s    = bank_sel_r;
    frame_cnt_s   = frame_cnt_r;
    drop_cnt_s    = drop_cnt_r;
    wr_en_s       = 1'b0;
    wr_data_s     = wr_data_r;
    wr_addr_s     = wr_addr_r;
    chirp_err_s   = 1'b0;
    timeout_err_s = timeout_err_r;
    set_mask_s    = 2'b00;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_s     = ST_WAIT_SYNC;
          chirp_idx_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_SYNC: begin
        if (sync_rise_s) begin
          skip_cnt_s   = '0;
          sample_idx_s = '0;
          if (chirp_idx_r == '0) begin
            state_s    = start_state_s;
            drop_cnt_s = drop_next_s;
          end else begin
            state_s = FIRST_ST;
          end
        end else if (chirp_idx_r != '0) begin
          // a missing sync mid-frame abandons the frame; the bank is reused
          if (tmo_cnt_r == TMO_LAST) begin
            timeout_err_s = 1'b1;
            chirp_idx_s   = '0;
          end else begin
            tmo_cnt_s = tmo_cnt_r + 1'b1;
          end
        end else begin
          tmo_cnt_s = '0;
        end
      end
      ST_DROP: begin
        if (sync_rise_s && !bank_ready_r[bank_sel_r]) begin
          state_s      = start_state_s;
          skip_cnt_s   = '0;
          sample_idx_s = '0;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_SKIP, ST_CAPTURE: begin
        if (sync_rise_s) begin
          chirp_err_s  = 1'b1;
          chirp_idx_s  = '0;
          skip_cnt_s   = '0;
          sample_idx_s = '0;
          state_s      = start_state_s;
          drop_cnt_s   = drop_next_s;
        end else if (!adc_valid) begin
          state_s = state_r;
        end else if (state_r == ST_SKIP) begin
          if (skip_cnt_r == SKIP_LAST) begin
            state_s = ST_CAPTURE;
          end else begin
            skip_cnt_s = skip_cnt_r + 1'b1;
          end
        end else begin
          wr_en_s   = 1'b1;
          wr_data_s = adc_data;
          wr_addr_s = ADDR_W'(chirp_idx_r) * ADDR_W'(SAMPLES_PER_CHIRP) + ADDR_W'(sample_idx_r);
          if (sample_idx_r == SAMPLE_LAST) begin
            sample_idx_s = '0;
            state_s      = ST_WAIT_SYNC;
            if (chirp_idx_r == CHIRP_LAST) begin
              set_mask_s  = bank_sel_r ? 2'b10 : 2'b01;
              frame_cnt_s = frame_cnt_r + 16'd1;
              bank_sel_s  = ~bank_sel_r;
              chirp_idx_s = '0;
            end else begin
              chirp_idx_s = chirp_idx_r + 1'b1;
            end
          end else begin
            sample_idx_s = sample_idx_r + 1'b1;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // a completing frame outranks a same-cycle reader release
    bank_ready_s = (bank_ready_r & ~bank_done) | set_mask_s;
  end

  // State, synchronizer and output registers
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      sync_meta_r   <= 1'b0;
      sync_sync_r   <= 1'b0;
      sync_prev_r   <= 1'b0;
      chirp_idx_r   <= '0;
      sample_idx_r  <= '0;
      skip_cnt_r    <= '0;
      tmo_cnt_r     <= '0;
      bank_sel_r    <= 1'b0;
      bank_ready_r  <= 2'b00;
      frame_cnt_r   <= 16'd0;
      drop_cnt_r    <= 8'd0;
      wr_en_r       <= 1'b0;
      wr_data_r     <= 16'd0;
      wr_addr_r     <= '0;
      wr_bank_r     <= 1'b0;
      chirp_err_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      sync_meta_r   <= sawtooth_dsync;
      sync_sync_r   <= sync_meta_r;
      sync_prev_r   <= sync_sync_r;
      chirp_idx_r   <= chirp_idx_s;
      sample_idx_r  <= sample_idx_s;
      skip_cnt_r    <= skip_cnt_s;
      tmo_cnt_r     <= tmo_cnt_s;
      bank_sel_r    <= bank_sel_s;
      bank_ready_r  <= bank_ready_s;
      frame_cnt_r   <= frame_cnt_s;
      drop_cnt_r    <= drop_cnt_s;
      wr_en_r       <= wr_en_s;
      wr_data_r     <= wr_data_s;
      wr_addr_r     <= wr_addr_s;
      // lags bank_sel so the final write of a frame still reports its own bank
      wr_bank_r     <= bank_sel_r;
      chirp_err_r   <= chirp_err_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign wr_en       = wr_en_r;
  assign wr_data     = wr_data_r;
  assign wr_addr     = wr_addr_r;
  assign wr_bank     = wr_bank_r;
  assign bank_ready  = bank_ready_r;
  assign frame_cnt   = frame_cnt_r;
  assign drop_cnt    = drop_cnt_r;
  assign chirp_err   = chirp_err_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_radar_frame_scheduler.sv
// Directed bench for radar_frame_scheduler with a small geometry (8 samples x 4 chirps).
module tb_radar_frame_scheduler;

  localparam int S   = 8;
  localparam int C   = 4;
  localparam int SK  = 2;
  localparam int TMO = 100;
  localparam int AW  = 16;

  logic          clk_50M = 1'b0;
  logic          reset;
  logic          sawtooth_dsync;
  logic          enable;
  logic          adc_valid;
  logic [15:0]   adc_data;
  logic          wr_en;
  logic [15:0]   wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_bank;
  logic [1:0]    bank_ready;
  logic [1:0]    bank_done;
  logic [15:0]   frame_cnt;
  logic [7:0]    drop_cnt;
  logic          chirp_err;
  logic          timeout_err;

  always #10 clk_50M = ~clk_50M;

  radar_frame_scheduler #(
    .SAMPLES_PER_CHIRP(S), .CHIRPS_PER_FRAME(C), .SKIP_SAMPLES(SK),
    .SYNC_TIMEOUT(TMO), .ADDR_W(AW)
  ) dut (
    .clk_50M(clk_50M), .reset(reset), .sawtooth_dsync(sawtooth_dsync),
    .enable(enable), .adc_valid(adc_valid), .adc_data(adc_data),
    .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .bank_ready(bank_ready), .bank_done(bank_done), .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt), .chirp_err(chirp_err), .timeout_err(timeout_err)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int data_bad = 0;
  int cerr_cnt = 0;
  logic [15:0] wa_q[$];
  logic        wb_q[$];
  logic [15:0] d_at_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    d_at_edge = adc_data;
    @(posedge clk_50M);
    #1;
    cyc++;
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wb_q.push_back(wr_bank);
      if (wr_data !== d_at_edge) data_bad++;
      last_wr_cyc = cyc;
    end
    if (chirp_err) cerr_cnt++;
    bank_done = 2'b00;
    adc_data  = adc_data + 16'd37;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sync_pulse();
    sawtooth_dsync = 1'b1;
    ticks(3);
    sawtooth_dsync = 1'b0;
    ticks(37);
  endtask

  task automatic frame();
    for (int i = 0; i < C; i++) sync_pulse();
  endtask

  task automatic clr_log();
    wa_q.delete();
    wb_q.delete();
    data_bad = 0;
  endtask

  // entries first..first+n-1 must be addresses base.. in the given bank
  task automatic chk_log(input string tag, input int first, input int n, input int base, input logic bank);
    int bad;
    bad = 0;
    if (wa_q.size() < first + n) begin
      bad = n;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (wa_q[first+i] !== 16'(base + i) || wb_q[first+i] !== bank) bad++;
      end
    end
    chk({tag, "_seq"}, bad, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctl"}, {27'd0, wr_en, wr_bank, bank_ready, chirp_err, timeout_err}, 32'd0);
    chk({tag, "_wr"}, {wr_data, wr_addr}, 32'd0);
    chk({tag, "_cnt"}, {8'd0, frame_cnt, drop_cnt}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sawtooth_dsync = 1'b0;
    adc_valid = 1'b1; adc_data = 16'h1234; bank_done = 2'b00;
    ticks(3);
    chk_reset_state("reset");
    reset = 1'b0; enable = 1'b1;
    ticks(2);

    // frame 1 -> bank 0
    clr_log();
    frame();
    chk("f1_writes", wa_q.size(), 32);
    chk_log("f1", 0, 32, 0, 1'b0);
    chk("f1_data", data_bad, 0);
    chk("f1_ready", bank_ready, 2'b01);
    chk("f1_frames", frame_cnt, 1);

    // frame 2 -> bank 1, then reader releases both banks
    clr_log();
    frame();
    chk("f2_writes", wa_q.size(), 32);
    chk_log("f2", 0, 32, 0, 1'b1);
    chk("f2_ready", bank_ready, 2'b11);
    chk("f2_frames", frame_cnt, 2);
    bank_done = 2'b01; tick();
    chk("done0_ready", bank_ready, 2'b10);
    bank_done = 2'b10; tick();
    chk("done1_ready", bank_ready, 2'b00);

    // frames 3 and 4 fill both banks
    clr_log();
    frame();
    chk_log("f3", 0, 32, 0, 1'b0);
    chk("f3_ready", bank_ready, 2'b01);
    chk("f3_frames", frame_cnt, 3);
    clr_log();
    frame();
    chk_log("f4", 0, 32, 0, 1'b1);
    chk("f4_ready", bank_ready, 2'b11);

    // both busy: next frame start is dropped
    clr_log();
    sync_pulse();
    chk("drop_cnt", drop_cnt, 1);
    chk("drop_nowr", wa_q.size(), 0);
    bank_done = 2'b01; tick();
    clr_log();
    frame();
    chk("f5_writes", wa_q.size(), 32);
    chk_log("f5", 0, 32, 0, 1'b0);
    chk("f5_ready", bank_ready, 2'b11);
    chk("f5_frames", frame_cnt, 5);
    chk("f5_drop", drop_cnt, 1);
    bank_done = 2'b11; tick();
    chk("done_both", bank_ready, 2'b00);

    // sync at sample 5 of chirp 2 aborts; the same sync restarts the frame in bank 1
    clr_log(); cerr_cnt = 0;
    sync_pulse();
    sync_pulse();
    sawtooth_dsync = 1'b1; ticks(2);
    sawtooth_dsync = 1'b0; ticks(6);
    sawtooth_dsync = 1'b1; ticks(3);
    sawtooth_dsync = 1'b0; ticks(34);
    for (int i = 0; i < C - 1; i++) sync_pulse();
    chk("ab_writes", wa_q.size(), 53);
    chk_log("ab_pre", 0, 21, 0, 1'b1);
    chk_log("ab_new", 21, 32, 0, 1'b1);
    chk("ab_cerr", cerr_cnt, 1);
    chk("ab_ready", bank_ready, 2'b10);
    chk("ab_frames", frame_cnt, 6);
    chk("ab_data", data_bad, 0);

    // sync stops after chirp 0 of a bank-0 frame
    clr_log();
    sync_pulse();
    begin
      int w;
      w = 0;
      while (!timeout_err && w < 300) begin
        tick();
        w++;
      end
    end
    chk("tmo_flag", timeout_err, 1'b1);
    chk("tmo_delay", cyc - last_wr_cyc, TMO);
    frame();
    chk("tmo_writes", wa_q.size(), 40);
    chk_log("tmo_pre", 0, 8, 0, 1'b0);
    chk_log("tmo_new", 8, 32, 0, 1'b0);
    chk("tmo_sticky", timeout_err, 1'b1);
    chk("tmo_ready", bank_ready, 2'b11);
    chk("tmo_frames", frame_cnt, 7);

    // reset in the middle of a chirp capture
    bank_done = 2'b11; tick();
    clr_log();
    sawtooth_dsync = 1'b1; ticks(3);
    sawtooth_dsync = 1'b0; ticks(6);
    chk("pre_rst_wr", wa_q.size() > 0, 1'b1);
    reset = 1'b1; tick();
    chk_reset_state("midrst");
    reset = 1'b0;
    ticks(5);

    // enable dropped mid-frame: frame completes, next start goes idle
    clr_log();
    sync_pulse();
    sync_pulse();
    enable = 1'b0;
    sync_pulse();
    sync_pulse();
    sync_pulse();
    chk("en_writes", wa_q.size(), 32);
    chk_log("en", 0, 32, 0, 1'b0);
    chk("en_ready", bank_ready, 2'b01);
    chk("en_frames", frame_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
